ftdi_fifo_master: RTL
=====================

# ftdi_fifo_master

FPGA-side master for the FTDI asynchronous 245-style byte FIFO on GPIO_0. It plays the opposite role to the FTDI chip: it watches `rxf_n` and `txe_n`, generates the active-low `ftdi_rd`/`ftdi_wr` strobes, and drives or samples the shared 8-bit ADBUS. Toward the core it exposes a valid/ready byte stream in each direction. It sits between ChipInterface pin assignments and the packet logic in `main`.

## Interface
- `RD_LOW_CYCLES`, 4: `ftdi_rd` low width in clocks (≥2)
- `RD_HIGH_CYCLES`, 3: minimum `ftdi_rd` high time after a read (≥3, covers synchronizer lag)
- `WR_LOW_CYCLES`, 2: `ftdi_wr` low width (≥1)
- `WR_HIGH_CYCLES`, 3: minimum `ftdi_wr` high time after a write (≥3)

Ports:
- `clock` in 1: system clock (CLOCK_50 domain); one clock, all flops on rising edge
- `resetN` in 1: reset, asynchronous, active-low
- `rxf_n` in 1: FTDI "data available", active-low, asynchronous
- `txe_n` in 1: FTDI "space available", active-low, asynchronous
- `adbus_in` in 8: ADBUS sampled value
- `adbus_out` out 8: ADBUS drive value
- `adbus_oe` out 1: ADBUS tristate enable (1 = FPGA drives)
- `ftdi_rd` out 1: read strobe, active-low
- `ftdi_wr` out 1: write strobe, active-low
- `rx_data` out 8: received byte
- `rx_valid` out 1: `rx_data` holds an unconsumed byte
- `rx_ready` in 1: consumer accepts; transfer on `rx_valid & rx_ready`
- `tx_data` in 8: byte to send
- `tx_valid` in 1: `tx_data` valid
- `tx_ready` out 1: byte accepted on `tx_valid & tx_ready`

## Operation
- `rxf_n` and `txe_n` each pass through a 2-flop synchronizer (`rxf_s`, `txe_s`). Both reset to 1. `adbus_in` is not synchronized because it is stable for the whole strobe.
- States: IDLE, RD_STROBE, RD_RECOVER, WR_SETUP, WR_STROBE, WR_RECOVER. All outputs are registered.
- IDLE:
  - Read is eligible when `rxf_s==0 && !rx_valid`.
  - Write is eligible when `txe_s==0 && tx_valid`.
  - If both are eligible, grant the opposite of `last_op`. `last_op` resets to WRITE, so the first contention grants read.
  - Read grant → RD_STROBE.
  - Write grant: `tx_ready`=1 for that one cycle, latch `tx_data` into the hold register → WR_SETUP.
- RD_STROBE: `ftdi_rd`=0 for RD_LOW_CYCLES cycles. On the edge ending the low period, `ftdi_rd`→1, `rx_data`←`adbus_in`, `rx_valid`→1 → RD_RECOVER.
- RD_RECOVER: RD_HIGH_CYCLES cycles → IDLE. `last_op`=READ.
- WR_SETUP: 1 cycle with `adbus_oe`=1, `adbus_out`=hold, `ftdi_wr`=1 → WR_STROBE.
- WR_STROBE: `ftdi_wr`=0 for WR_LOW_CYCLES cycles; data is held → WR_RECOVER.
- WR_RECOVER: `ftdi_wr`=1. `adbus_oe` stays 1 for the first cycle (hold time), then goes to 0. After WR_HIGH_CYCLES cycles → IDLE. `last_op`=WRITE.
- `rx_valid` clears on `rx_valid & rx_ready`. `rx_data` is held until then. No new read starts while `rx_valid`=1 (backpressure: FTDI keeps the data).
- Invariant: `adbus_oe`=1 and `ftdi_rd`=0 are never true together. `ftdi_rd` and `ftdi_wr` are never both 0.

## Timing
- Reset values (applied asynchronously, including mid-strobe):
  - `ftdi_rd`=1, `ftdi_wr`=1, `adbus_oe`=0, `adbus_out`=0
  - `rx_data`=0, `rx_valid`=0, `tx_ready`=0
  - state IDLE, synchronizers=1, `last_op`=WRITE
- Read latency:
  - `rxf_n` low before edge E0 → `rxf_s` low after E1 → IDLE decides at E2 → `ftdi_rd` low from E2.
  - `ftdi_rd` is low for exactly RD_LOW_CYCLES clocks.
  - `rx_valid` rises on the same edge that `ftdi_rd` rises.
- Read period: minimum RD_LOW+RD_HIGH+1 clocks per byte (8 at defaults).
- Write:
  - `tx_ready` pulse at edge W0.
  - `adbus_oe` rises at W0+1 (WR_SETUP).
  - `ftdi_wr` is low from W0+2 for WR_LOW_CYCLES clocks.
  - `adbus_oe` falls 1 clock after `ftdi_wr` rises.
- `tx_ready` is only ever a single-cycle pulse in IDLE; it is never asserted when `tx_valid`=0.
- `rxf_n` or `txe_n` deasserting mid-strobe has no effect. The strobe completes at full width.

## Test plan
- Single read: `rxf_n`=0, FTDI model drives 0xA5 while `ftdi_rd`=0, `rx_ready`=1 → `ftdi_rd` low exactly 4 clocks, `rx_data`=0xA5 with `rx_valid` for 1 cycle, `adbus_oe`=0 throughout.
- Backpressure: `rxf_n` held 0, bytes 0x01, 0x02, 0x03, `rx_ready`=0 for 20 clocks then 1 → exactly one strobe during the stall; bytes delivered in order 0x01, 0x02, 0x03, none lost or duplicated.
- Single write: `txe_n`=0, `tx_valid`=1, `tx_data`=0x3C → one `tx_ready` pulse; `adbus_out`=0x3C with `adbus_oe`=1 from 1 clock before `ftdi_wr` falls until 1 clock after it rises; `ftdi_wr` low 2 clocks.
- Contention: `rxf_n`=0 and `txe_n`=0 with `tx_valid`=1 for 4 transfers → order read, write, read, write; `ftdi_rd` and `ftdi_wr` never low together; `adbus_oe` never 1 while `ftdi_rd`=0.
- FTDI full: `txe_n`=1, `tx_valid`=1 → `tx_ready` stays 0 and `ftdi_wr` stays 1; drop `txe_n` → write proceeds within 3 clocks.
- Reset mid-RD_STROBE: `resetN`=0 asynchronously → `ftdi_rd`=1 and `rx_valid`=0 immediately (before next edge); after release, the next read completes normally.

Source files
------------

// File: rtl/ftdi_fifo_master.sv
// FPGA-side master for the FTDI asynchronous 245-style byte FIFO.
// Arbitrates reads and writes on the shared ADBUS and exposes valid/ready byte streams to the core.
module ftdi_fifo_master #(
    parameter int unsigned RD_LOW_CYCLES  = 4,
    parameter int unsigned RD_HIGH_CYCLES = 3,
    parameter int unsigned WR_LOW_CYCLES  = 2,
    parameter int unsigned WR_HIGH_CYCLES = 3
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       rxf_n,
    input  logic       txe_n,
    input  logic [7:0] adbus_in,
    output logic [7:0] adbus_out,
    output logic       adbus_oe,
    output logic       ftdi_rd,
    output logic       ftdi_wr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] RD_STROBE  = 3'd1;
    localparam logic [2:0] RD_RECOVER = 3'd2;
    localparam logic [2:0] WR_SETUP   = 3'd3;
    localparam logic [2:0] WR_STROBE  = 3'd4;
    localparam logic [2:0] WR_RECOVER = 3'd5;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    logic       rxf_meta, rxf_s, txe_meta, txe_s;
    logic [2:0] state;
    logic [7:0] cnt;
    logic [7:0] hold;
    logic       last_op;
    logic       rd_ok, wr_ok, grant_rd, grant_wr;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
            txe_meta <= 1'b1;
            txe_s    <= 1'b1;
        end else begin
            rxf_meta <= rxf_n;
            rxf_s    <= rxf_meta;
            txe_meta <= txe_n;
            txe_s    <= txe_meta;
        end
    end

    // On contention the operation not performed last wins, so neither direction starves.
    always_comb begin
        rd_ok    = !rxf_s && !rx_valid;
        wr_ok    = !txe_s && tx_valid;
        grant_rd = (state == IDLE) && rd_ok && (!wr_ok || last_op == OP_WRITE);
        grant_wr = (state == IDLE) && wr_ok && !grant_rd;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            last_op   <= OP_WRITE;
            ftdi_rd   <= 1'b1;
            ftdi_wr   <= 1'b1;
            adbus_oe  <= 1'b0;
            adbus_out <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b0;
        end else begin
            tx_ready <= 1'b0;
            // A byte can only land while rx_valid is low, so the set below never races this clear.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        ftdi_rd <= 1'b0;
                        cnt     <= 8'(RD_LOW_CYCLES - 1);
                        state   <= RD_STROBE;
                    end else if (grant_wr) begin
                        tx_ready <= 1'b1;
                        hold     <= tx_data;
                        state    <= WR_SETUP;
                    end
                end
                RD_STROBE: begin
                    if (cnt == '0) begin
                        ftdi_rd  <= 1'b1;
                        rx_data  <= adbus_in;
                        rx_valid <= 1'b1;
                        cnt      <= 8'(RD_HIGH_CYCLES - 1);
                        state    <= RD_RECOVER;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_RECOVER: begin
                    last_op <= OP_READ;
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                WR_SETUP: begin
                    adbus_oe  <= 1'b1;
                    adbus_out <= hold;
                    cnt       <= 8'(WR_LOW_CYCLES);
                    state     <= WR_STROBE;
                end
                WR_STROBE: begin
                    if (cnt == '0) begin
                        ftdi_wr <= 1'b1;
                        cnt     <= 8'(WR_HIGH_CYCLES - 1);
                        state   <= WR_RECOVER;
                    end else begin
                        ftdi_wr <= 1'b0;
                        cnt     <= cnt - 1'b1;
                    end
                end
                WR_RECOVER: begin
                    // Bus stays driven for the first recovery cycle to give the FTDI hold time.
                    adbus_oe <= 1'b0;
                    last_op  <= OP_WRITE;
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
